// File: rtl/fa_adder_pkg.sv
// Shared constants and result type for the ripple full-adder unit.
// Combinational only; no latency; no backpressure.
// Optional overflow outputs are enabled by FA_ADDER_OVF_EN.
package fa_adder_pkg;

    localparam int FA_DEFAULT_WIDTH = 1;

    // Result layout at the default width; wider instances build the same shape locally.
    typedef struct packed {
        logic                        carry;
        logic [FA_DEFAULT_WIDTH-1:0] sum;
    } fa_res_t;

endpackage : fa_adder_pkg

// File: rtl/fa_adder_unit_if.sv
// Operand/result bundle for fa_adder_unit; dut side consumes a/b/c, tb side drives them.
// No state; no latency; no backpressure (in_valid only qualifies the registered copy).
// Overflow signals exist only when FA_ADDER_OVF_EN is defined.
interface fa_adder_unit_if
    import fa_adder_pkg::*;
#(
    parameter int WIDTH = FA_DEFAULT_WIDTH
);
    logic             in_valid;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             c;
    logic [WIDTH-1:0] sum;
    logic             carry;
    logic [WIDTH-1:0] sum_q;
    logic             carry_q;
    logic             out_valid;
`ifdef FA_ADDER_OVF_EN
    logic             ovf;
    logic             ovf_q;
`endif

    modport dut (
        input  in_valid, a, b, c,
        output sum, carry, sum_q, carry_q, out_valid
`ifdef FA_ADDER_OVF_EN
        , output ovf, ovf_q
`endif
    );

    modport tb (
        output in_valid, a, b, c,
        input  sum, carry, sum_q, carry_q, out_valid
`ifdef FA_ADDER_OVF_EN
        , input ovf, ovf_q
`endif
    );

endinterface : fa_adder_unit_if

// File: rtl/fa_adder_unit_cell.sv
// Single-bit full adder cell used as one stage of the ripple chain.
// Purely combinational; zero latency; no backpressure.
module fa_cell (
    input  logic x,
    input  logic y,
    input  logic ci,
    output logic s,
    output logic co
);

    assign s  = x ^ y ^ ci;
    assign co = (x & y) | (y & ci) | (ci & x);

endmodule : fa_cell

// File: rtl/fa_adder_unit.sv
// Ripple-carry adder {carry,sum} = a + b + c with a registered, valid-qualified copy.
// Latency: combinational path 0 cycles, registered path 1 cycle; no backpressure.
// FA_ADDER_OVF_EN adds signed-overflow outputs ovf / ovf_q.
module fa_adder_unit
    import fa_adder_pkg::*;
#(
    parameter int WIDTH = FA_DEFAULT_WIDTH
)(
    input  logic           clk,
    input  logic           rst_n,
    fa_adder_unit_if.dut   bus
);

    typedef struct packed {
        logic             carry;
        logic [WIDTH-1:0] sum;
    } res_t;

    // cy[i] is the carry into cell i; cy[WIDTH] is the final carry-out.
    logic [WIDTH:0]   cy;
    logic [WIDTH-1:0] s;
    res_t             res_d;
    res_t             res_q;
    logic             vld_q;

    assign cy[0] = bus.c;

    genvar g;
    for (g = 0; g < WIDTH; g++) begin : g_cell
        fa_cell u_cell (
            .x  (bus.a[g]),
            .y  (bus.b[g]),
            .ci (cy[g]),
            .s  (s[g]),
            .co (cy[g+1])
        );
    end

    assign res_d.carry = cy[WIDTH];
    assign res_d.sum   = s;

    assign bus.sum   = s;
    assign bus.carry = cy[WIDTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_q <= '0;
            vld_q <= 1'b0;
        end else begin
            vld_q <= bus.in_valid;
            if (bus.in_valid) begin
                res_q <= res_d;
            end
        end
    end

    assign bus.sum_q     = res_q.sum;
    assign bus.carry_q   = res_q.carry;
    assign bus.out_valid = vld_q;

`ifdef FA_ADDER_OVF_EN
    // Signed overflow: carry into the MSB disagrees with carry out of it.
    logic ovf_d;
    logic ovf_q;

    assign ovf_d = cy[WIDTH-1] ^ cy[WIDTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_q <= 1'b0;
        end else if (bus.in_valid) begin
            ovf_q <= ovf_d;
        end
    end

    assign bus.ovf   = ovf_d;
    assign bus.ovf_q = ovf_q;
`endif

endmodule : fa_adder_unit

// File: tb/tb_fa_adder_unit.sv
// Directed, table-driven bench for fa_adder_unit at WIDTH=1 and WIDTH=8.
module tb_fa_adder_unit;

    logic clk;
    logic rst_n;
    int   passed;
    int   total;

    fa_adder_unit_if #(.WIDTH(1)) if1 ();
    fa_adder_unit_if #(.WIDTH(8)) if8 ();

    fa_adder_unit #(.WIDTH(1)) u_dut1 (.clk(clk), .rst_n(rst_n), .bus(if1));
    fa_adder_unit #(.WIDTH(8)) u_dut8 (.clk(clk), .rst_n(rst_n), .bus(if8));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       a;
        logic       b;
        logic       c;
        logic       sum;
        logic       carry;
    } vec1_t;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       c;
        logic [7:0] sum;
        logic       carry;
        logic       ovf;
    } vec8_t;

    vec1_t tv1 [8];
    vec8_t tv8 [5];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) begin
            passed++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive8(input logic vld, input logic [7:0] a, input logic [7:0] b, input logic c);
        if8.in_valid = vld;
        if8.a        = a;
        if8.b        = b;
        if8.c        = c;
    endtask

    initial begin
        passed = 0;
        total  = 0;

        tv1[0] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        tv1[1] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        tv1[2] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        tv1[3] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        tv1[4] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        tv1[5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        tv1[6] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
        tv1[7] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1};

        tv8[0] = '{8'hFF, 8'h00, 1'b1, 8'h00, 1'b1, 1'b0};
        tv8[1] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1};
        tv8[2] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1};
        tv8[3] = '{8'h12, 8'h34, 1'b1, 8'h47, 1'b0, 1'b0};
        tv8[4] = '{8'hC8, 8'h64, 1'b0, 8'h2C, 1'b1, 1'b0};

        rst_n        = 1'b1;
        if1.in_valid = 1'b0;
        if1.a        = 1'b0;
        if1.b        = 1'b0;
        if1.c        = 1'b0;
        drive8(1'b0, 8'h00, 8'h00, 1'b0);

        #2 rst_n = 1'b0;
        #1;
        check("rst_sum_q",     32'(if1.sum_q),     32'd0);
        check("rst_carry_q",   32'(if1.carry_q),   32'd0);
        check("rst_out_valid", 32'(if1.out_valid), 32'd0);
        check("rst_out_valid8", 32'(if8.out_valid), 32'd0);

        // Combinational truth table, applied while reset is still held.
        for (int i = 0; i < 8; i++) begin
            if1.a = tv1[i].a;
            if1.b = tv1[i].b;
            if1.c = tv1[i].c;
            #1;
            check($sformatf("w1_sum[%0d]", i),   32'(if1.sum),   32'(tv1[i].sum));
            check($sformatf("w1_carry[%0d]", i), 32'(if1.carry), 32'(tv1[i].carry));
        end

        for (int i = 0; i < 5; i++) begin
            drive8(1'b0, tv8[i].a, tv8[i].b, tv8[i].c);
            #1;
            check($sformatf("w8_sum[%0d]", i),   32'(if8.sum),   32'(tv8[i].sum));
            check($sformatf("w8_carry[%0d]", i), 32'(if8.carry), 32'(tv8[i].carry));
`ifdef FA_ADDER_OVF_EN
            check($sformatf("w8_ovf[%0d]", i),   32'(if8.ovf),   32'(tv8[i].ovf));
`endif
        end

        // in_valid held high during reset must not capture.
        if1.in_valid = 1'b1;
        if1.a = 1'b1; if1.b = 1'b1; if1.c = 1'b1;
        @(posedge clk); #1;
        check("rst_ignore_vld", 32'(if1.out_valid), 32'd0);
        check("rst_ignore_sum", 32'(if1.sum_q),     32'd0);

        // Registered path, WIDTH=1.
        @(negedge clk);
        rst_n = 1'b1;
        if1.in_valid = 1'b1;
        if1.a = 1'b1; if1.b = 1'b0; if1.c = 1'b1;
        @(posedge clk); #1;
        check("reg_sum_q",     32'(if1.sum_q),     32'd0);
        check("reg_carry_q",   32'(if1.carry_q),   32'd1);
        check("reg_out_valid", 32'(if1.out_valid), 32'd1);
        if1.in_valid = 1'b0;
        if1.a = 1'b0; if1.b = 1'b0; if1.c = 1'b0;
        @(posedge clk); #1;
        check("hold_out_valid", 32'(if1.out_valid), 32'd0);
        check("hold_sum_q",     32'(if1.sum_q),     32'd0);
        check("hold_carry_q",   32'(if1.carry_q),   32'd1);

        // Back-to-back stream of 4 on WIDTH=8.
        drive8(1'b1, tv8[0].a, tv8[0].b, tv8[0].c);
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            check($sformatf("b2b_vld[%0d]", i),   32'(if8.out_valid), 32'd1);
            check($sformatf("b2b_sum[%0d]", i),   32'(if8.sum_q),     32'(tv8[i].sum));
            check($sformatf("b2b_carry[%0d]", i), 32'(if8.carry_q),   32'(tv8[i].carry));
`ifdef FA_ADDER_OVF_EN
            check($sformatf("b2b_ovf[%0d]", i),   32'(if8.ovf_q),     32'(tv8[i].ovf));
`endif
            if (i < 3) drive8(1'b1, tv8[i+1].a, tv8[i+1].b, tv8[i+1].c);
            else       drive8(1'b0, 8'h00, 8'h00, 1'b0);
        end
        @(posedge clk); #1;
        check("b2b_end_vld", 32'(if8.out_valid), 32'd0);
        check("b2b_end_sum", 32'(if8.sum_q),     32'(tv8[3].sum));

        // Asynchronous reset between edges with a result pending.
        drive8(1'b1, 8'hFF, 8'h00, 1'b1);
        @(posedge clk); #1;
        check("pre_arst_vld",   32'(if8.out_valid), 32'd1);
        check("pre_arst_carry", 32'(if8.carry_q),   32'd1);
        drive8(1'b1, 8'h7F, 8'h01, 1'b0);
        #1 rst_n = 1'b0;
        #1;
        check("arst_vld",    32'(if8.out_valid), 32'd0);
        check("arst_sum_q",  32'(if8.sum_q),     32'd0);
        check("arst_carry",  32'(if8.carry_q),   32'd0);
        check("arst_comb_s", 32'(if8.sum),       32'h80);
        check("arst_comb_c", 32'(if8.carry),     32'd0);

        // First edge after release captures.
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("rel_vld",   32'(if8.out_valid), 32'd1);
        check("rel_sum_q", 32'(if8.sum_q),     32'h80);
        check("rel_carry", 32'(if8.carry_q),   32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule : tb_fa_adder_unit
